vco_band_sel_fsm: RTL and testbench

//  Sequential coarse-band (cap-bank) calibration engine for the FLL ahead of the PLL loop.
//  On start it drives the VCO band code (cfs) by successive approximation (SAR), MSB first.

---
 rtl/vco_band_sel_fsm.sv | 196 +++++++++++++++++++
 tb/tb_vco_band_sel_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vco_band_sel_fsm.sv
// Coarse VCO band calibration: SAR search of the cap-bank code against a counted target.
// Optional nearest-code refinement after the SAR pass is enabled by defining VCO_BAND_SEL_REFINE_EN.
module vco_band_sel_fsm #(
    parameter int CFS_W       = 6,
    parameter int N_W         = 8,
    parameter int FRAC_W      = 4,
    parameter int WIN_LOG2    = 8,
    parameter int CNT_W       = 24,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_W-1:0]    n_int,
    input  logic [FRAC_W:0]   alpha,
    output logic              meas_req,
    input  logic              meas_vld,
    input  logic [CNT_W-1:0]  meas_cnt,
    output logic [CFS_W-1:0]  cfs,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        fsm_state
);

    localparam int TW     = CNT_W + 2;
    localparam int BIT_W  = (CFS_W > 1) ? $clog2(CFS_W) : 1;
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CFS_W-1:0] CFS_MID = CFS_W'(1) << (CFS_W - 1);

    // S_FIN is the single done-pulse cycle; S_DONE holds the result afterwards.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_MEAS   = 3'd2,
        S_DECIDE = 3'd3,
        S_FIN    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Handshake: meas_req is a 1-cycle pulse opening a count window; the counter answers with a
    // 1-cycle meas_vld carrying meas_cnt. Only a meas_vld seen while in S_MEAS is consumed.

    state_t             state_q, state_d;
    logic [CFS_W-1:0]   cfs_q, dec_code;
    logic [BIT_W-1:0]   bit_q;
    logic [SET_W-1:0]   settle_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   tgt_q, cnt_q, tgt_sat;
    logic [TW-1:0]      tgt_sum, tgt_raw;
    logic               err_q, keep, settle_end, timeout, accept;
`ifdef VCO_BAND_SEL_REFINE_EN
    logic               refine_q;
    logic [CNT_W-1:0]   cnt_c_q, err_lo, err_hi;
`endif

    always_comb begin
        tgt_sum = {{(TW-N_W-FRAC_W){1'b0}}, n_int, {FRAC_W{1'b0}}}
                + {{(TW-FRAC_W-1){alpha[FRAC_W]}}, alpha};
        tgt_raw = tgt_sum << (WIN_LOG2 - FRAC_W);
        if (tgt_raw[TW-1])
            tgt_sat = '0;
        else if (tgt_raw[TW-2:CNT_W] != '0)
            tgt_sat = '1;
        else
            tgt_sat = tgt_raw[CNT_W-1:0];
    end

    assign keep       = (cnt_q < tgt_q);
    assign settle_end = (settle_cnt == SET_W'(SETTLE_CYC - 1));
    assign timeout    = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
    assign accept     = start && (state_q == S_IDLE || state_q == S_FIN || state_q == S_DONE);

    always_comb begin
        dec_code = cfs_q;
        if (!keep) dec_code[bit_q] = 1'b0;
    end

`ifdef VCO_BAND_SEL_REFINE_EN
    assign err_lo = (cnt_c_q >= tgt_q) ? (cnt_c_q - tgt_q) : (tgt_q - cnt_c_q);
    assign err_hi = (cnt_q   >= tgt_q) ? (cnt_q   - tgt_q) : (tgt_q - cnt_q);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_SETTLE;
            S_FIN:          state_d = start ? S_SETTLE : S_DONE;
            S_SETTLE:       if (settle_end) state_d = S_MEAS;
            S_MEAS: begin
                if (meas_vld)     state_d = S_DECIDE;
                else if (timeout) state_d = S_IDLE;
            end
            S_DECIDE: begin
`ifdef VCO_BAND_SEL_REFINE_EN
                if (refine_q)                state_d = S_FIN;
                else if (bit_q != '0)        state_d = S_SETTLE;
                else if (dec_code != '1)     state_d = S_SETTLE;
                else                         state_d = S_FIN;
`else
                if (bit_q != '0) state_d = S_SETTLE;
                else             state_d = S_FIN;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        meas_req  = (state_q == S_MEAS) && (wait_cnt == '0);
        busy      = (state_q == S_SETTLE) || (state_q == S_MEAS) || (state_q == S_DECIDE);
        done      = (state_q == S_FIN);
        err       = err_q;
        cfs       = cfs_q;
        fsm_state = state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfs_q      <= CFS_MID;
            err_q      <= 1'b0;
            tgt_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            settle_cnt <= '0;
            wait_cnt   <= '0;
`ifdef VCO_BAND_SEL_REFINE_EN
            refine_q   <= 1'b0;
            cnt_c_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_FIN, S_DONE: begin
                    if (accept) begin
                        tgt_q      <= tgt_sat;
                        err_q      <= 1'b0;
                        cfs_q      <= CFS_MID;
                        bit_q      <= BIT_W'(CFS_W - 1);
                        settle_cnt <= '0;
`ifdef VCO_BAND_SEL_REFINE_EN
                        refine_q   <= 1'b0;
                        // Code 0 is never measured; seeding with the target keeps a saturated-low result.
                        cnt_c_q    <= tgt_sat;
`endif
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    wait_cnt   <= '0;
                end
                S_MEAS: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (meas_vld)     cnt_q <= meas_cnt;
                    else if (timeout) err_q <= 1'b1;
                end
                S_DECIDE: begin
                    settle_cnt <= '0;
`ifdef VCO_BAND_SEL_REFINE_EN
                    if (refine_q) begin
                        refine_q <= 1'b0;
                        if (err_hi >= err_lo) cfs_q <= cfs_q - 1'b1;
                    end else
`endif
                    begin
`ifdef VCO_BAND_SEL_REFINE_EN
                        // The SAR result is always the last kept trial, so its count is captured here.
                        if (keep) cnt_c_q <= cnt_q;
`endif
                        if (bit_q != '0) begin
                            cfs_q <= dec_code | (CFS_W'(1) << (bit_q - 1'b1));
                            bit_q <= bit_q - 1'b1;
                        end
`ifdef VCO_BAND_SEL_REFINE_EN
                        else if (dec_code != '1) begin
                            cfs_q    <= dec_code + 1'b1;
                            refine_q <= 1'b1;
                        end
`endif
                        else begin
                            cfs_q <= dec_code;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vco_band_sel_fsm.sv
// Bench for vco_band_sel_fsm: vector table of SAR runs against a VCO count model, plus
// timeout, mid-run reset and start-while-busy sequences. Honours VCO_BAND_SEL_REFINE_EN.
module tb_vco_band_sel_fsm;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  n_int;
    logic [4:0]  alpha;
    logic        meas_req;
    logic        meas_vld;
    logic [23:0] meas_cnt;
    logic [5:0]  cfs;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    logic vco_en;

    vco_band_sel_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_int     (n_int),
        .alpha     (alpha),
        .meas_req  (meas_req),
        .meas_vld  (meas_vld),
        .meas_cnt  (meas_cnt),
        .cfs       (cfs),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] n;
        logic [4:0] a;
        logic [5:0] cfs_sar;
        logic [5:0] cfs_ref;
        int         reqs_ref;
    } vec_t;

    vec_t vecs[7];

    // floor((9e9 + code*37.8e6) / 150e6 * 256) = floor(15360 + code*64.512)
    function automatic logic [23:0] vco_cnt(input logic [5:0] code);
        int v;
        v = (15360000 + int'(code) * 64512) / 1000;
        return 24'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Counter model: answers each meas_req three cycles later with the count for the current code.
    initial begin
        logic [5:0] code;
        meas_vld = 1'b0;
        meas_cnt = '0;
        forever begin
            @(negedge clk);
            if (meas_req && vco_en) begin
                code = cfs;
                repeat (3) @(negedge clk);
                meas_vld = 1'b1;
                meas_cnt = vco_cnt(code);
                @(negedge clk);
                meas_vld = 1'b0;
            end
        end
    end

    task automatic run_cal(input logic [7:0] n, input logic [4:0] a, input int inj_at,
                           output int reqs, output int dones, output logic [5:0] res);
        logic got;
        logic [5:0] held;
        reqs  = 0;
        dones = 0;
        got   = 1'b0;
        @(negedge clk);
        n_int = n;
        alpha = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_after_start", err, 0);
        chk("cfs_after_start", cfs, 32);
        for (int i = 0; i < 4000; i++) begin
            if (meas_req) reqs++;
            if (done) begin
                dones++;
                got = 1'b1;
                break;
            end
            start = (i == inj_at);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("busy_in_done_cycle", busy, 0);
        res  = cfs;
        held = cfs;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("cfs_held_in_done", cfs, held);
        chk("state_done", fsm_state, 5);
    endtask

    initial begin
        int reqs, dones, k;
        logic [5:0] res;
        logic got;

        vecs[0] = '{8'd66,  5'd0,       6'd23, 6'd24, 7};
        vecs[1] = '{8'd60,  5'b11000,   6'd0,  6'd0,  7};
        vecs[2] = '{8'd255, 5'd15,      6'd63, 6'd63, 6};
        vecs[3] = '{8'd64,  5'd0,       6'd15, 6'd16, 7};
        vecs[4] = '{8'd70,  5'd5,       6'd40, 6'd41, 7};
        vecs[5] = '{8'd63,  5'b11101,   6'd11, 6'd11, 7};
        vecs[6] = '{8'd0,   5'b11111,   6'd0,  6'd0,  7};

        rst_n  = 1'b0;
        start  = 1'b0;
        n_int  = '0;
        alpha  = '0;
        vco_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cfs", cfs, 32);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_meas_req", meas_req, 0);
        chk("rst_state", fsm_state, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            run_cal(vecs[v].n, vecs[v].a, -1, reqs, dones, res);
`ifdef VCO_BAND_SEL_REFINE_EN
            chk($sformatf("vec%0d_cfs", v), res, vecs[v].cfs_ref);
            chk($sformatf("vec%0d_reqs", v), reqs, vecs[v].reqs_ref);
`else
            chk($sformatf("vec%0d_cfs", v), res, vecs[v].cfs_sar);
            chk($sformatf("vec%0d_reqs", v), reqs, 6);
`endif
            chk($sformatf("vec%0d_dones", v), dones, 1);
            chk($sformatf("vec%0d_err", v), err, 0);
        end

        // start while busy must be ignored
        run_cal(8'd66, 5'd0, 20, reqs, dones, res);
`ifdef VCO_BAND_SEL_REFINE_EN
        chk("busy_start_cfs", res, 24);
        chk("busy_start_reqs", reqs, 7);
`else
        chk("busy_start_cfs", res, 23);
        chk("busy_start_reqs", reqs, 6);
`endif
        chk("busy_start_dones", dones, 1);

        // timeout: counter never answers
        vco_en = 1'b0;
        @(negedge clk);
        n_int = 8'd66;
        alpha = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (meas_req) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("timeout_req_seen", got, 1);
        k = 0;
        got = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            k++;
            if (err) begin
                got = 1'b1;
                break;
            end
        end
        chk("timeout_err_seen", got, 1);
        chk("timeout_cycles", k, 1024);
        chk("timeout_busy", busy, 0);
        chk("timeout_cfs", cfs, 32);
        chk("timeout_state", fsm_state, 0);
        vco_en = 1'b1;
        run_cal(8'd66, 5'd0, -1, reqs, dones, res);
`ifdef VCO_BAND_SEL_REFINE_EN
        chk("after_timeout_cfs", res, 24);
`else
        chk("after_timeout_cfs", res, 23);
`endif
        chk("after_timeout_err", err, 0);

        // reset while measuring bit 3; the late meas_vld must be ignored
        @(negedge clk);
        n_int = 8'd66;
        alpha = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reqs = 0;
        for (int i = 0; i < 200; i++) begin
            if (meas_req) reqs++;
            if (reqs == 3) break;
            @(negedge clk);
        end
        chk("rst_mid_reached_bit3", reqs, 3);
        chk("rst_mid_cfs_before", cfs, 24);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_cfs", cfs, 32);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_state", fsm_state, 0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_mid_stale_dones", dones, 0);
        chk("rst_mid_stale_state", fsm_state, 0);
        chk("rst_mid_stale_cfs", cfs, 32);
        chk("rst_mid_stale_busy", busy, 0);

        run_cal(8'd66, 5'd0, -1, reqs, dones, res);
`ifdef VCO_BAND_SEL_REFINE_EN
        chk("after_rst_cfs", res, 24);
`else
        chk("after_rst_cfs", res, 23);
`endif
        chk("after_rst_dones", dones, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
